// File: rtl/vga_startup_seq.sv
// PLL lock filter and power-up sequencer: holds the Pong core in reset until lock is stable,
// then enables video. Define VGA_STARTUP_SEQ_FRAME_SYNC_EN to wait for a frame boundary first.
module vga_startup_seq #(
  parameter int SETTLE_CYCLES    = 250000,
  parameter int RESET_CYCLES     = 16,
  parameter int FRAME_TIMEOUT    = 500000,
  parameter int VSYNC_ACTIVE_LOW = 1,
  parameter int CNT_W            = 19
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET_N,
  input  logic       PLL_LOCKED,
  input  logic       VGA_VSYNC,
  output logic       CORE_RESET,
  output logic       VIDEO_EN,
  output logic       READY,
  output logic [7:0] FAULT_COUNT
);

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_SETTLE    = 3'd1;
  localparam logic [2:0] ST_RESET     = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd4;
`ifdef VGA_STARTUP_SEQ_FRAME_SYNC_EN
  localparam logic [2:0] ST_SYNC      = 3'd3;
`endif

  logic             r_lock_meta;
  logic             r_lock_s;
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_fault_cnt;
  logic             w_fault_src;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking here would
  // collapse the two synchronizer stages into one.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= PLL_LOCKED;
      r_lock_s    <= r_lock_meta;
    end
  end

`ifdef VGA_STARTUP_SEQ_FRAME_SYNC_EN
  logic r_vs_q;
  logic r_vs_qq;
  logic r_frame_seen;
  logic w_vs_active;
  logic w_vs_edge;

  assign w_vs_active = (VSYNC_ACTIVE_LOW != 0) ? ~VGA_VSYNC : VGA_VSYNC;
  assign w_vs_edge   = r_vs_q & ~r_vs_qq;

  // First active edge inside SYNC only arms; the second marks a complete frame.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vs_q       <= 1'b0;
      r_vs_qq      <= 1'b0;
      r_frame_seen <= 1'b0;
    end else begin
      r_vs_q  <= w_vs_active;
      r_vs_qq <= r_vs_q;
      if (r_state != ST_SYNC)
        r_frame_seen <= 1'b0;
      else if (w_vs_edge)
        r_frame_seen <= 1'b1;
    end
  end

  assign w_fault_src = (r_state == ST_SYNC) || (r_state == ST_RUN);
`else
  logic w_unused;
  assign w_unused    = VGA_VSYNC ^ (FRAME_TIMEOUT == 0) ^ (VSYNC_ACTIVE_LOW == 0);
  assign w_fault_src = (r_state == ST_RUN);
`endif

  // NOTE: w_state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_LOCK: if (r_lock_s) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!r_lock_s)
          w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1))
          w_state_nxt = ST_RESET;
      end
      ST_RESET: begin
        if (!r_lock_s)
          w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == CNT_W'(RESET_CYCLES - 1))
`ifdef VGA_STARTUP_SEQ_FRAME_SYNC_EN
          w_state_nxt = ST_SYNC;
`else
          w_state_nxt = ST_RUN;
`endif
      end
`ifdef VGA_STARTUP_SEQ_FRAME_SYNC_EN
      ST_SYNC: begin
        if (!r_lock_s)
          w_state_nxt = ST_WAIT_LOCK;
        else if ((w_vs_edge && r_frame_seen) || (r_cnt == CNT_W'(FRAME_TIMEOUT - 1)))
          w_state_nxt = ST_RUN;
      end
`endif
      ST_RUN:  if (!r_lock_s) w_state_nxt = ST_WAIT_LOCK;
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Single shared counter: zero on every transition, so a lock glitch restarts settle from 0.
  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_fault_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if ((r_state != ST_WAIT_LOCK) && (r_state != ST_RUN))
        r_cnt <= r_cnt + CNT_W'(1);
      if ((w_state_nxt == ST_WAIT_LOCK) && w_fault_src && (r_fault_cnt != 8'hFF))
        r_fault_cnt <= r_fault_cnt + 8'd1;
    end
  end

  assign CORE_RESET  = (r_state == ST_WAIT_LOCK) || (r_state == ST_SETTLE) || (r_state == ST_RESET);
  assign VIDEO_EN    = (r_state == ST_RUN);
  assign READY       = (r_state == ST_RUN);
  assign FAULT_COUNT = r_fault_cnt;

endmodule

// File: tb/tb_vga_startup_seq.sv
// Self-checking bench for vga_startup_seq: randomized lock/vsync stimulus against a
// timeline model (elapsed cycles since settle start) plus directed latency checks.
module tb_vga_startup_seq;

  localparam int S   = 8;
  localparam int R   = 4;
  localparam int FT  = 40;
  localparam int VAL = 1;
  localparam bit VS_IDLE = (VAL != 0);

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       PLL_LOCKED;
  logic       VGA_VSYNC;
  logic       CORE_RESET;
  logic       VIDEO_EN;
  logic       READY;
  logic [7:0] FAULT_COUNT;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  bit vs_rand  = 1'b0;

  vga_startup_seq #(
    .SETTLE_CYCLES(S), .RESET_CYCLES(R), .FRAME_TIMEOUT(FT),
    .VSYNC_ACTIVE_LOW(VAL), .CNT_W(6)
  ) dut (
    .CLK_25MHZ(clk), .RESET_N(RESET_N), .PLL_LOCKED(PLL_LOCKED), .VGA_VSYNC(VGA_VSYNC),
    .CORE_RESET(CORE_RESET), .VIDEO_EN(VIDEO_EN), .READY(READY), .FAULT_COUNT(FAULT_COUNT)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: once locked_s is seen high, the sequence is described purely by the number
  // of cycles elapsed since settle began; video starts at S+R (or after the frame wait).
  bit m_meta, m_lks, m_in_seq, m_run, m_va, m_va_d;
  int m_start, m_edge, m_nedges, m_fault;

  task automatic model_reset();
    m_meta = 0; m_lks = 0; m_in_seq = 0; m_run = 0; m_va = 0; m_va_d = 0;
    m_start = 0; m_edge = 0; m_nedges = 0; m_fault = 0;
  endtask

  task automatic model_step();
    int el;
    el = m_edge - m_start;
    if (!m_in_seq) begin
      if (m_lks) begin
        m_in_seq = 1; m_start = m_edge + 1; m_run = 0; m_nedges = 0;
      end
    end else if (!m_lks) begin
      if (el >= S + R && m_fault < 255) m_fault++;
      m_in_seq = 0; m_run = 0;
    end
`ifdef VGA_STARTUP_SEQ_FRAME_SYNC_EN
    else if (el >= S + R && !m_run) begin
      if (m_va && !m_va_d) begin
        m_nedges++;
        if (m_nedges == 2) m_run = 1;
      end
      if (el - (S + R) == FT - 1) m_run = 1;
    end
`endif
    m_va_d = m_va;
    m_va   = (VAL != 0) ? !VGA_VSYNC : VGA_VSYNC;
    m_lks  = m_meta;
    m_meta = PLL_LOCKED;
    m_edge++;
  endtask

  always @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) model_reset();
    else          model_step();
  end

  bit e_cr, e_ve;
  always @(negedge clk) begin
    if (chk_en) begin
      e_cr = !m_in_seq || (m_edge - m_start) < S + R;
`ifdef VGA_STARTUP_SEQ_FRAME_SYNC_EN
      e_ve = m_in_seq && m_run;
`else
      e_ve = m_in_seq && (m_edge - m_start) >= S + R;
`endif
      check("core_reset", int'(CORE_RESET), int'(e_cr));
      check("video_en", int'(VIDEO_EN), int'(e_ve));
      check("ready", int'(READY), int'(e_ve));
      check("fault_count", int'(FAULT_COUNT), m_fault);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
      if (vs_rand && $urandom_range(0, 5) == 0) VGA_VSYNC = ~VGA_VSYNC;
    end
  endtask

  // Counts cycles until the selected output reaches the wanted level; bound expiry returns -1.
  task automatic wait_out(input int sel, input bit level, input int bound, output int n);
    bit v;
    n = 0;
    do begin
      tick(1);
      n++;
      v = (sel == 0) ? CORE_RESET : VIDEO_EN;
    end while (v != level && n < bound);
    if (v != level) n = -1;
  endtask

  int n;

  initial begin
    RESET_N = 0; PLL_LOCKED = 0; VGA_VSYNC = VS_IDLE;
    repeat (3) @(negedge clk);
    chk_en = 1;
    @(negedge clk); #2;
    check("rst_core_reset", int'(CORE_RESET), 1);
    check("rst_video_en", int'(VIDEO_EN), 0);
    RESET_N = 1;

    // Short lock pulse: settle must restart, nothing released, no fault
    PLL_LOCKED = 1; tick(5);
    PLL_LOCKED = 0; tick(6);
    check("glitch_core_reset", int'(CORE_RESET), 1);
    check("glitch_fault", int'(FAULT_COUNT), 0);

    // Clean lock-up with vsync inactive; a pulse during settle must be ignored
    PLL_LOCKED = 1;
    tick(4); VGA_VSYNC = ~VS_IDLE; tick(2); VGA_VSYNC = VS_IDLE;
    wait_out(0, 1'b0, 100, n);
    check("release_latency", n + 6, 15);
`ifdef VGA_STARTUP_SEQ_FRAME_SYNC_EN
    check("video_held_in_sync", int'(VIDEO_EN), 0);
    wait_out(1, 1'b1, 100, n);
    check("sync_timeout_cycles", n, FT);
`else
    check("video_with_release", int'(VIDEO_EN), 1);
`endif
    check("ready_in_run", int'(READY), 1);

    // Lock drop in RUN
    PLL_LOCKED = 0;
    wait_out(0, 1'b1, 20, n);
    check("lock_loss_latency", n, 3);
    check("lock_loss_video", int'(VIDEO_EN), 0);
    check("lock_loss_fault", int'(FAULT_COUNT), 1);
    tick(2);

    // Relock and reach RUN through a real frame boundary
    PLL_LOCKED = 1;
    wait_out(0, 1'b0, 100, n);
    check("relock_release", n, 15);
`ifdef VGA_STARTUP_SEQ_FRAME_SYNC_EN
    tick(3); VGA_VSYNC = ~VS_IDLE; tick(2); VGA_VSYNC = VS_IDLE; tick(10);
    check("one_frame_edge_only", int'(VIDEO_EN), 0);
    VGA_VSYNC = ~VS_IDLE;
    wait_out(1, 1'b1, 20, n);
    check("frame_edge_latency", n, 2);
    VGA_VSYNC = VS_IDLE;
`endif
    tick(3);

    // Random lock/vsync activity
    vs_rand = 1;
    for (int i = 0; i < 40; i++) begin
      PLL_LOCKED = 1; tick($urandom_range(1, 90));
      PLL_LOCKED = 0; tick($urandom_range(1, 5));
    end

    // Drive the fault counter into saturation
    for (int i = 0; i < 260; i++) begin
      PLL_LOCKED = 1;
      wait_out(1, 1'b1, 150, n);
      if (n < 0) check("run_reached_timeout", n, 0);
      tick($urandom_range(0, 3));
      PLL_LOCKED = 0;
      tick(3);
    end
    check("fault_saturated", int'(FAULT_COUNT), 255);

    // Asynchronous reset in the middle of settle
    vs_rand = 0;
    PLL_LOCKED = 1; tick(6);
    #3 RESET_N = 0;
    #1;
    check("midreset_core_reset", int'(CORE_RESET), 1);
    check("midreset_video_en", int'(VIDEO_EN), 0);
    check("midreset_ready", int'(READY), 0);
    check("midreset_fault", int'(FAULT_COUNT), 0);
    @(negedge clk); #2 RESET_N = 1;
    tick(70);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_startup_seq.md
# vga_startup_seq

Power-up and recovery sequencer between the 25 MHz PLL and the Pong core on the DE0-Nano build. It filters the PLL lock indication, holds the core in reset until the clock has been stable for a programmable time, and releases a video enable only at a clean frame boundary. It re-runs the whole sequence whenever lock is lost and counts those faults.

## Interface
- SETTLE_CYCLES, 250000: cycles of continuous lock required before core reset sequencing (10 ms at 25 MHz).
- RESET_CYCLES, 16: extra cycles CORE_RESET stays high after settle.
- FRAME_TIMEOUT, 500000: max cycles to wait for a frame boundary in SYNC (20 ms).
- VSYNC_ACTIVE_LOW, 1: 1 means VGA_VSYNC pulse is low-active.
- CNT_W, 19: shared counter width; must hold max(SETTLE_CYCLES, RESET_CYCLES, FRAME_TIMEOUT)-1.
- CLK_25MHZ  in  1  sole clock, PLL output.
- RESET_N  in  1  asynchronous active-low reset; deassertion is synchronous to CLK_25MHZ upstream.
- PLL_LOCKED  in  1  raw PLL lock, asynchronous; 2-flop synchronized internally (locked_s).
- VGA_VSYNC  in  1  vsync from core, CLK_25MHZ domain.
- CORE_RESET  out  1  active-high reset to core.
- VIDEO_EN  out  1  gates RGB at board top (0 = black).
- READY  out  1  high in RUN.
- FAULT_COUNT  out  8  saturating count of lock losses from SYNC/RUN.

## Operation
- Moore FSM, all outputs decoded from registered state/counters, no combinational input-to-output path.
- States: WAIT_LOCK, SETTLE, RESET, SYNC, RUN. One counter, cleared on every state transition.
- WAIT_LOCK: CORE_RESET=1, VIDEO_EN=0, READY=0. locked_s=1 -> SETTLE.
- SETTLE: counter increments; counter==SETTLE_CYCLES-1 -> RESET.
- RESET: CORE_RESET=1; counter==RESET_CYCLES-1 -> SYNC (or RUN, see Configuration).
- SYNC: CORE_RESET=0, VIDEO_EN=0. Active vsync edge = transition into active level (1-cycle delayed compare). Second active edge seen in SYNC -> RUN (first complete frame). Counter==FRAME_TIMEOUT-1 without it -> RUN anyway. Edges before SYNC are ignored.
- RUN: CORE_RESET=0, VIDEO_EN=1, READY=1. Stays until lock loss.
- Lock loss: locked_s=0 in SETTLE/RESET/SYNC/RUN -> WAIT_LOCK on next edge; has priority over any simultaneous counter terminal or vsync event. FAULT_COUNT+1 only when leaving SYNC or RUN; saturates at 255, never wraps.
- Lock glitch shorter than settle restarts settle from 0 (no accumulation).
- RESET_N low (any time, mid-sequence included): state WAIT_LOCK, sync flops 0, counter 0, FAULT_COUNT 0, CORE_RESET=1, VIDEO_EN=0, READY=0.

## Timing
- Reference edge E0: first edge sampling PLL_LOCKED=1. locked_s high after E1; state SETTLE after E2.
- RESET entered after E(2+SETTLE_CYCLES); CORE_RESET falls after E(2+SETTLE_CYCLES+RESET_CYCLES).
- SYNC -> RUN: VIDEO_EN/READY rise on the edge after the second active vsync edge is registered.
- Lock loss: PLL_LOCKED low before edge F0 -> CORE_RESET=1, VIDEO_EN=0 after F2 (3 edges).
- Throughput: one transition per cycle max; counter never exceeds terminal value.

## Configuration
- VGA_STARTUP_SEQ_FRAME_SYNC_EN defined: SYNC state built as above; VIDEO_EN rises only at a frame boundary or timeout.
- Undefined: SYNC and vsync edge logic removed; RESET -> RUN directly, VIDEO_EN/READY rise on the same edge CORE_RESET falls; VGA_VSYNC and FRAME_TIMEOUT unused.

## Test plan
- Bench params SETTLE=8, RESET=4, FRAME_TIMEOUT=40, macro on. Lock high at E0 -> CORE_RESET low after E14; VIDEO_EN=0 until second vsync edge; VIDEO_EN=READY=1 one edge after.
- Lock pulse of 5 cycles then low, then stable high -> settle restarts; CORE_RESET never falls during pulse; FAULT_COUNT stays 0.
- VGA_VSYNC held inactive in SYNC -> RUN after exactly 40 cycles in SYNC.
- Lock drop in RUN -> CORE_RESET=1, VIDEO_EN=0 after F2; FAULT_COUNT 0->1; relock repeats full sequence.
- 260 lock drops from RUN -> FAULT_COUNT=255; RESET_N pulse mid-SETTLE -> all outputs at reset values, FAULT_COUNT=0.
- Macro off: lock at E0 -> CORE_RESET falls and VIDEO_EN/READY rise together after E14, vsync ignored.
